// File: rtl/vga_scan_compositor.sv
// 640x480@60 VGA scan generator that fetches sprite pixels by coordinate and
// composites them over a background colour into RGB888 with sync/blank.
module vga_scan_compositor #(
  parameter int          H_VISIBLE  = 640,
  parameter int          H_FRONT    = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BACK     = 48,
  parameter int          V_VISIBLE  = 480,
  parameter int          V_FRONT    = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BACK     = 33,
  parameter int          PIX_DIV    = 2,
  parameter int          SPRITE_LAT = 2,
  parameter logic [7:0]  BG_COLOR   = 8'h3B
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       visible_flag,
  output logic [9:0] current_pixel_x,
  output logic [9:0] current_pixel_y,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vblank_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_VISIBLE);
  localparam logic [9:0] V_ACT    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] VBL_PREV = 10'(V_VISIBLE - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic             pix_tick;
  logic [9:0]       h_cnt_reg;
  logic [9:0]       v_cnt_reg;
  logic             h_wrap;
  logic             v_wrap;
  logic             tick_reg;
  logic             vblank_start_reg;
  logic             active;
  logic             hs_raw;
  logic             vs_raw;
  logic [3:0]       align_out;
  logic             d_tick;
  logic             d_active;
  logic             d_hs;
  logic             d_vs;
  logic [7:0]       colour;

  assign pix_tick = (div_cnt_reg == DIV_LAST);
  assign h_wrap   = (h_cnt_reg == H_LAST);
  assign v_wrap   = (v_cnt_reg == V_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_reg <= '0;
    end else if (pix_tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_ONE;
    end
  end

  // tick_reg marks the clk on which a freshly updated coordinate is on the bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_reg        <= '0;
      v_cnt_reg        <= '0;
      tick_reg         <= 1'b0;
      vblank_start_reg <= 1'b0;
    end else begin
      tick_reg         <= pix_tick;
      vblank_start_reg <= pix_tick && h_wrap && (v_cnt_reg == VBL_PREV);
      if (pix_tick) begin
        if (h_wrap) begin
          h_cnt_reg <= '0;
          v_cnt_reg <= v_wrap ? 10'd0 : v_cnt_reg + 10'd1;
        end else begin
          h_cnt_reg <= h_cnt_reg + 10'd1;
        end
      end
    end
  end

  assign current_pixel_x = h_cnt_reg;
  assign current_pixel_y = v_cnt_reg;
  assign vblank_start    = vblank_start_reg;

  assign active = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
  assign hs_raw = !((h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END));
  assign vs_raw = !((v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END));

  // Timing flags ride alongside the sprite ROM pipeline so they meet its data
  genvar gi;
  generate
    for (gi = 0; gi < SPRITE_LAT; gi++) begin : g_dly
      logic [3:0] stage_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            stage_reg <= '0;
          end else begin
            stage_reg <= {tick_reg, active, hs_raw, vs_raw};
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            stage_reg <= '0;
          end else begin
            stage_reg <= g_dly[gi-1].stage_reg;
          end
        end
      end
    end
  endgenerate

  assign align_out = g_dly[SPRITE_LAT-1].stage_reg;
  assign {d_tick, d_active, d_hs, d_vs} = align_out;

  always_comb begin
    colour = 8'h00;
    if (d_active) begin
      colour = visible_flag ? data : BG_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else if (d_tick) begin
      vga_r       <= {colour[7:5], colour[7:5], colour[7:6]};
      vga_g       <= {colour[4:2], colour[4:2], colour[4:3]};
      vga_b       <= {colour[1:0], colour[1:0], colour[1:0], colour[1:0]};
      vga_hs      <= d_hs;
      vga_vs      <= d_vs;
      vga_blank_n <= d_active;
    end
  end

endmodule

// File: doc/vga_scan_compositor.md
Name: vga_scan_compositor

Overview:
Initiator side of the sprite pixel-fetch interface. It generates 640x480@60 VGA scan timing from the system clock and drives current_pixel_x/current_pixel_y to the sprite ROM block. It samples the returned data/visible_flag at the correct pipeline delay and composites sprite pixels over a background colour. It then emits RGB888 plus sync/blank signals to the VGA DAC.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
PIX_DIV, 2, clk cycles per pixel; must be >= SPRITE_LAT
SPRITE_LAT, 2, clk cycles from coordinate change to valid data/visible_flag
BG_COLOR, 8'h3B, RGB332 background colour

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  reset, asynchronous and active-low (asserted when 0)
data  in  8  RGB332 sprite pixel from sprite ROM block
visible_flag  in  1  sprite pixel is opaque
current_pixel_x  out  10  horizontal scan counter, 0..H_TOTAL-1
current_pixel_y  out  10  vertical scan counter, 0..V_TOTAL-1
vga_r  out  8  red channel
vga_g  out  8  green channel
vga_b  out  8  blue channel
vga_hs  out  1  hsync, active-low
vga_vs  out  1  vsync, active-low
vga_blank_n  out  1  1 during the active region, aligned with RGB
vblank_start  out  1  one-clk pulse when the scan enters line V_VISIBLE; used as game-logic frame strobe

Behaviour:
- Derived totals: H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525.
- Reset (rst=0, async): clear div_cnt, h_cnt, v_cnt and all delay-line stages.
  - Output reset values: current_pixel_x=0, current_pixel_y=0, RGB=0, vga_hs=1, vga_vs=1, vga_blank_n=0, vblank_start=0.
- Pixel divider:
  - div_cnt counts 0..PIX_DIV-1.
  - pix_tick=1 on the clk where div_cnt==PIX_DIV-1.
  - After reset release, the first tick occurs on the PIX_DIV-th rising edge.
- Scan counters (advance only on pix_tick):
  - h_cnt increments; it wraps H_TOTAL-1 -> 0.
  - On an h wrap, v_cnt increments; it wraps V_TOTAL-1 -> 0.
  - current_pixel_x/y are registered copies of h_cnt/v_cnt and update on the tick edge.
- Raw sync/active (combinational from the counters):
  - active = h_cnt<H_VISIBLE && v_cnt<V_VISIBLE.
  - hs_raw = 0 iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC.
  - vs_raw = 0 iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC.
- Alignment delay line:
  - {pix_tick, active, hs_raw, vs_raw} pass through a SPRITE_LAT-deep clk shift register.
  - This matches the sprite path (1 clk ROM read + 1 clk output register).
- Output stage, on the clk where delayed tick==1:
  - vga_hs/vga_vs/vga_blank_n take the delayed values.
  - colour c = delayed active ? (visible_flag ? data : BG_COLOR) : 8'h00.
  - RGB expansion: vga_r={c[7:5],c[7:5],c[7:6]}, vga_g={c[4:2],c[4:2],c[4:3]}, vga_b={c[1:0],c[1:0],c[1:0],c[1:0]}.
  - All outputs hold between delayed ticks.
  - Total latency from coordinate update to RGB update = SPRITE_LAT+1 clk.
- vblank_start:
  - Registered one-clk pulse on the tick edge where v_cnt changes from V_VISIBLE-1 to V_VISIBLE (h wrap).
  - It is not delayed.
- During blanking, data/visible_flag are ignored; RGB is forced to 0 even if visible_flag=1.
- Reset asserted mid-line or mid-frame: all outputs return to reset values immediately. On release, the scan restarts at (0,0) with no partial-line output.

Test Plan:
- Reset: hold rst=0 for 5 clk with arbitrary inputs -> x=y=0, RGB=0, hs=vs=1, blank_n=0. Release -> first x increment (x=1) on the 2nd rising edge.
- Line timing: run 1 line -> tick every 2 clk, line period 1600 clk, vga_hs low exactly 192 clk starting 1312 clk after x=0 (+SPRITE_LAT+1 offset), blank_n high 1280 clk.
- Frame timing: run 1 frame -> 525 lines (840000 clk), vga_vs low exactly 2 lines from line 490, vblank_start pulses once per frame (width 1 clk) when y becomes 480.
- Compositing: model ROM with 2-clk latency. Return visible_flag=1, data=8'hE0 for x=100,y=50 -> that pixel outputs R=8'hFF, G=0, B=0 with blank_n=1. Neighbours with visible_flag=0 -> R=8'h24, G=8'hDB, B=8'hFF.
- Blanking: force visible_flag=1, data=8'hFF while x>=640 -> RGB=0, blank_n=0.
- Reset mid-frame: assert rst at x=300,y=200 -> outputs return to reset values asynchronously (before next edge). Release -> scan restarts at (0,0), next vblank_start after exactly 480 lines.
